lattice_test_sequencer: RTL and testbench

LATTICE_TEST_SEQUENCER -- requirements
Module: lattice_test_sequencer

---
 rtl/lattice_seq_pkg.sv | 9 +
 rtl/lattice_golden.sv | 15 +
 rtl/lattice_test_sequencer.sv | 84 ++++++++
 tb/tb_lattice_test_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lattice_seq_pkg.sv
// lattice_seq_pkg: shared FSM encoding, LFSR polynomial and helper for the lattice test sequencer
package lattice_seq_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, WAIT = 3'd2, CHECK = 3'd3, FIN = 3'd4} seqState_e;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;
  function automatic logic [31:0] lfsrNext(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'd0);
  endfunction
endpackage

// File: rtl/lattice_golden.sv
// lattice_golden: closed-form response of DEPTH serial XOR/NOT stages on IO_PAIRS bit pairs
module lattice_golden #(
  parameter int IO_PAIRS = 8,
  parameter int DEPTH = 1
) (
  input  logic [2*IO_PAIRS-1:0] vecIn,
  output logic [2*IO_PAIRS-1:0] expOut
);
  localparam logic depthOdd = 1'(DEPTH % 2);
  localparam logic depthHalf = 1'((DEPTH / 2) % 2);
  for (genvar p = 0; p < IO_PAIRS; p++) begin : g_pair
    assign expOut[2*p] = vecIn[2*p] ^ depthOdd;
    assign expOut[2*p+1] = vecIn[2*p+1] ^ (depthOdd & vecIn[2*p]) ^ depthHalf;
  end
endmodule

// File: rtl/lattice_test_sequencer.sv
// lattice_test_sequencer: drives LFSR vectors into a lattice, checks responses, reports pass/errors
module lattice_test_sequencer import lattice_seq_pkg::*; #(
  parameter int IO_PAIRS = 8,
  parameter int DEPTH = 1,
  parameter int SETTLE = 2,
  parameter int NUM_VECTORS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           seed,
  output logic [2*IO_PAIRS-1:0] lat_in,
  input  logic [2*IO_PAIRS-1:0] lat_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [15:0]           first_err_idx
);
  localparam int W = 2 * IO_PAIRS;
  seqState_e state;
  logic [31:0] lfsr;
  logic [15:0] idx;
  logic [7:0] waitCnt;
  logic aborted, passHeld, mismatch;
  logic [W-1:0] latOutQ, expOut;
  lattice_golden #(.IO_PAIRS(IO_PAIRS), .DEPTH(DEPTH)) uGolden (.vecIn(lat_in), .expOut(expOut));
  assign mismatch = latOutQ != expOut;
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign pass = done ? (err_count == 16'd0 && !aborted) : passHeld;
  // lat_out is captured one edge before CHECK so the sample lands SETTLE cycles after lat_in moves
  always_ff @(posedge clk) latOutQ <= lat_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_in <= '0;
      err_count <= '0;
      first_err_idx <= NO_ERR_IDX;
      lfsr <= 32'd1;
      idx <= '0;
      waitCnt <= '0;
      aborted <= 1'b0;
      passHeld <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= LOAD;
        lfsr <= seed == '0 ? 32'd1 : seed;
        idx <= '0;
        err_count <= '0;
        first_err_idx <= NO_ERR_IDX;
        aborted <= 1'b0;
        passHeld <= 1'b0;
      end
    end else if (abort && state != FIN) begin
      state <= FIN;
      aborted <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          lat_in <= lfsr[W-1:0];
          waitCnt <= 8'(SETTLE - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (waitCnt == 8'd0) state <= CHECK;
          else waitCnt <= waitCnt - 8'd1;
        end
        CHECK: begin
          if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (mismatch && err_count == 16'd0) first_err_idx <= idx;
          lfsr <= lfsrNext(lfsr);
          idx <= idx + 16'd1;
          state <= (idx == 16'(NUM_VECTORS - 1)) ? FIN : LOAD;
        end
        default: begin
          passHeld <= pass;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lattice_test_sequencer.sv
// tb_lattice_test_sequencer: self-checking bench with a stage-by-stage lattice model and LFSR scoreboard
module tb_lattice_test_sequencer;
  localparam int NVEC = 256;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst, start, abort;
  logic [31:0] seed;
  logic [W-1:0] lat_in, lat_out;
  logic busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic faultEn, faultVal;
  logic [3:0] faultBit;
  logic [W-1:0] gIn, g1, g2, g3;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic [15:0] vin, e1, e2, e3;} goldVec_t;
  goldVec_t tbl [4];

  always #5 clk = ~clk;

  lattice_test_sequencer #(.IO_PAIRS(8), .DEPTH(1), .SETTLE(2), .NUM_VECTORS(NVEC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
    .lat_in(lat_in), .lat_out(lat_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );
  lattice_golden #(.IO_PAIRS(8), .DEPTH(1)) gold1 (.vecIn(gIn), .expOut(g1));
  lattice_golden #(.IO_PAIRS(8), .DEPTH(2)) gold2 (.vecIn(gIn), .expOut(g2));
  lattice_golden #(.IO_PAIRS(8), .DEPTH(3)) gold3 (.vecIn(gIn), .expOut(g3));

  // each stage: odd line becomes odd^even, even line is inverted
  function automatic logic [W-1:0] lattice(input logic [W-1:0] v, input int depth);
    logic [W-1:0] r;
    r = v;
    for (int s = 0; s < depth; s++)
      for (int p = 0; p < W / 2; p++) begin
        r[2*p+1] = r[2*p+1] ^ r[2*p];
        r[2*p] = ~r[2*p];
      end
    return r;
  endfunction

  function automatic logic [31:0] lfsrStep(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'd0);
  endfunction

  always_comb begin
    lat_out = lattice(lat_in, 1);
    if (faultEn) lat_out[faultBit] = faultVal;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [31:0] sd, input int nVec, output int errs, output int first);
    logic [31:0] x;
    logic [W-1:0] good, seen;
    x = (sd == 32'd0) ? 32'd1 : sd;
    errs = 0;
    first = 16'hFFFF;
    for (int v = 0; v < nVec; v++) begin
      good = lattice(x[W-1:0], 1);
      seen = good;
      if (faultEn) seen[faultBit] = faultVal;
      if (seen != good) begin
        if (errs == 0) first = v;
        errs++;
      end
      x = lfsrStep(x);
    end
  endtask

  // start cycle is k=0; abort (if any) is high during cycle abortAt
  task automatic run(input logic [31:0] sd, input int abortAt, output int doneAt);
    seed = sd;
    start = 1'b1;
    doneAt = -1;
    for (int k = 1; k < 3000 && doneAt < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == abortAt);
      if (done) doneAt = k;
    end
    abort = 1'b0;
    check("done_seen", doneAt > 0, 1);
  endtask

  task automatic expectRun(input string tag, input logic [31:0] sd, input int abortAt);
    int doneAt, errs, first, n;
    logic expPass;
    n = abortAt > 0 ? (abortAt - 1) / 4 : NVEC;
    model(sd, n, errs, first);
    expPass = errs == 0 && abortAt == 0;
    run(sd, abortAt, doneAt);
    check({tag, "_cycles"}, doneAt + 1, abortAt > 0 ? abortAt + 2 : 4 * NVEC + 2);
    check({tag, "_pass"}, pass, expPass);
    check({tag, "_err"}, err_count, errs);
    check({tag, "_first"}, first_err_idx, first);
    check({tag, "_busy_fin"}, busy, 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_after"}, done, 0);
    repeat (3) @(negedge clk);
    check({tag, "_err_hold"}, err_count, errs);
    check({tag, "_first_hold"}, first_err_idx, first);
    check({tag, "_pass_hold"}, pass, expPass);
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_lat_in"}, lat_in, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_first"}, first_err_idx, 16'hFFFF);
  endtask

  initial begin
    logic [31:0] x;
    int k1, k2, idle;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seed = '0;
    faultEn = 1'b0;
    faultBit = '0;
    faultVal = 1'b0;
    gIn = '0;
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b0;
    @(negedge clk);
    tbl[0] = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF};
    tbl[1] = '{16'h0003, 16'h5554, 16'hAAA9, 16'hFFFE};
    tbl[2] = '{16'h0001, 16'h5556, 16'hAAAB, 16'hFFFC};
    tbl[3] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA};
    for (int i = 0; i < 4; i++) begin
      gIn = tbl[i].vin;
      #1;
      check("golden_d1", g1, tbl[i].e1);
      check("golden_d2", g2, tbl[i].e2);
      check("golden_d3", g3, tbl[i].e3);
    end
    expectRun("clean_seed1", 32'd1, 0);
    faultEn = 1'b1;
    faultBit = 4'd3;
    faultVal = 1'b0;
    expectRun("stuck3_seed1", 32'd1, 0);
    expectRun("stuck3_seed0", 32'd0, 0);
    x = 32'd1;
    for (int i = 0; i < 10; i++) x = lfsrStep(x);
    faultBit = 4'd0;
    faultVal = x[0];
    expectRun("abort_v10_check", 32'd1, 44);
    expectRun("abort_v10_wait", 32'd1, 42);
    faultBit = 4'd3;
    seed = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("rst_wait");
    faultEn = 1'b0;
    expectRun("after_rst", 32'd1, 0);
    abort = 1'b1;
    expectRun("start_abort", 32'd1, 0);
    seed = 32'h1234;
    start = 1'b1;
    k1 = -1;
    k2 = -1;
    idle = 0;
    for (int k = 1; k < 4000 && k2 < 0; k++) begin
      @(negedge clk);
      if (!busy) idle++;
      if (done && k1 < 0) k1 = k;
      else if (done) k2 = k;
    end
    start = 1'b0;
    check("held_first_done", k1 + 1, 4 * NVEC + 2);
    check("held_gap", k2 - k1, 4 * NVEC + 2);
    check("held_idle_cycles", idle, 1);
    check("held_pass", pass, 1);
    repeat (2) @(negedge clk);
    check("held_stop_busy", busy, 0);
    for (int r = 0; r < 6; r++) begin
      faultEn = 1'($urandom_range(0, 1));
      faultBit = 4'($urandom_range(0, 15));
      faultVal = 1'($urandom_range(0, 1));
      expectRun("rnd", $urandom, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * NVEC) : 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
